// File: rtl/qwi_reg_pkg.sv
// Shared mode encodings and default widths for the qwi register bank.
package qwi_reg_pkg;

  typedef enum logic [1:0] {
    MODE_RW    = 2'd0,
    MODE_RO    = 2'd1,
    MODE_W1C   = 2'd2,
    MODE_PULSE = 2'd3
  } reg_mode_e;

  localparam int DEF_REGCNT = 32;
  localparam int DEF_AWID   = 12;
  localparam int DEF_DWID   = 32;

endpackage

// File: rtl/qwi_reg_cell.sv
// One register of the qwi bank; MODE selects RW, RO, W1C or PULSE behaviour.
// Build option QWI_REG_SHADOW_EN adds a commit-gated output copy for RW registers.
module qwi_reg_cell
  import qwi_reg_pkg::*;
#(
  parameter int               DWID = DEF_DWID,
  parameter reg_mode_e        MODE = MODE_RW,
  parameter logic [DWID-1:0]  INIT = '0
) (
  input  logic                reg_clk,
  input  logic                reg_rst,
  input  logic                wr_en,
  input  logic [DWID/8-1:0]   wr_be,
  input  logic [DWID-1:0]     wr_data,
  input  logic [DWID-1:0]     reg_in,
  input  logic [DWID-1:0]     reg_evt,
  input  logic                reg_commit,
  output logic [DWID-1:0]     rd_val,
  output logic [DWID-1:0]     out_val
);

  localparam int NBYTE = DWID / 8;
  localparam logic [DWID-1:0] RST_VAL =
    (MODE == MODE_RW || MODE == MODE_RO) ? INIT : '0;

  logic [DWID-1:0] be_mask;
  logic [DWID-1:0] wr_mask;
  logic [DWID-1:0] val_reg;
  logic [DWID-1:0] val_next;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTE; gi++) begin : g_byte
      assign be_mask[gi*8 +: 8] = {8{wr_be[gi]}};
    end
  endgenerate

  assign wr_mask = wr_en ? be_mask : '0;

  always_comb begin
    val_next = val_reg;
    case (MODE)
      MODE_RW:  val_next = (val_reg & ~wr_mask) | (wr_data & wr_mask);
      MODE_RO:  val_next = reg_in;
      // OR-ing the events after the clear makes a coincident set win.
      MODE_W1C: val_next = (val_reg & ~(wr_data & wr_mask)) | reg_evt;
      default:  val_next = wr_data & wr_mask;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      val_reg <= RST_VAL;
    end else begin
      val_reg <= val_next;
    end
  end

  assign rd_val = (MODE == MODE_PULSE) ? '0 : val_reg;

`ifdef QWI_REG_SHADOW_EN
  // val_reg acts as the shadow; fabric only sees it after a commit.
  logic [DWID-1:0] commit_reg;

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      commit_reg <= INIT;
    end else if (reg_commit) begin
      commit_reg <= val_reg;
    end
  end

  assign out_val = (MODE == MODE_RW) ? commit_reg : val_reg;

  logic unused_cell;
  assign unused_cell = ^{reg_in, reg_evt, wr_data, commit_reg};
`else
  assign out_val = val_reg;

  logic unused_cell;
  assign unused_cell = ^{reg_in, reg_evt, wr_data, reg_commit};
`endif

endmodule

// File: rtl/qwi_reg_bank.sv
// Register bank: address decode, registered read port and range error around qwi_reg_cell.
// Build option QWI_REG_SHADOW_EN enables shadowed RW registers with reg_commit.
module qwi_reg_bank
  import qwi_reg_pkg::*;
#(
  parameter int                        REGCNT   = DEF_REGCNT,
  parameter int                        AWID     = DEF_AWID,
  parameter int                        DWID     = DEF_DWID,
  parameter logic [DWID*REGCNT-1:0]    REG_INIT = '0,
  parameter logic [2*REGCNT-1:0]       REG_MODE = '0
) (
  input  logic                         reg_clk,
  input  logic                         reg_rst,
  input  logic                         reg_ce,
  input  logic [DWID/8-1:0]            reg_we,
  input  logic                         reg_re,
  input  logic [AWID-1:0]              reg_addr,
  input  logic [DWID-1:0]              reg_wrd,
  output logic [DWID-1:0]              reg_rdd,
  output logic                         reg_rvld,
  output logic                         reg_err,
  input  logic [DWID*REGCNT-1:0]       reg_in,
  input  logic [DWID*REGCNT-1:0]       reg_evt,
  input  logic                         reg_commit,
  output logic [DWID*REGCNT-1:0]       reg_out
);

  logic [REGCNT-1:0] sel;
  logic [DWID-1:0]   rd_vals [REGCNT];
  logic [DWID-1:0]   rd_mux;
  logic              wr_req;
  logic              rd_req;
  logic              in_range;

  logic [DWID-1:0]   rdd_reg;
  logic              rvld_reg;
  logic              err_reg;

  assign wr_req = reg_ce & (|reg_we);
  assign rd_req = reg_ce & reg_re;

  genvar gi;
  generate
    for (gi = 0; gi < REGCNT; gi++) begin : g_reg
      assign sel[gi] = (reg_addr == AWID'(gi));

      qwi_reg_cell #(
        .DWID (DWID),
        .MODE (reg_mode_e'(REG_MODE[2*gi +: 2])),
        .INIT (REG_INIT[gi*DWID +: DWID])
      ) u_cell (
        .reg_clk    (reg_clk),
        .reg_rst    (reg_rst),
        .wr_en      (wr_req & sel[gi]),
        .wr_be      (reg_we),
        .wr_data    (reg_wrd),
        .reg_in     (reg_in[gi*DWID +: DWID]),
        .reg_evt    (reg_evt[gi*DWID +: DWID]),
        .reg_commit (reg_commit),
        .rd_val     (rd_vals[gi]),
        .out_val    (reg_out[gi*DWID +: DWID])
      );
    end
  endgenerate

  // No select bit matches an out-of-range address, so the mux yields zero there.
  assign in_range = |sel;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < REGCNT; i++) begin
      if (sel[i]) begin
        rd_mux = rd_mux | rd_vals[i];
      end
    end
  end

  // rd_mux sees pre-edge state, so a same-cycle write is not visible to the read.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      rdd_reg  <= '0;
      rvld_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      rvld_reg <= rd_req;
      err_reg  <= (rd_req | wr_req) & ~in_range;
      if (rd_req) begin
        rdd_reg <= rd_mux;
      end
    end
  end

  assign reg_rdd  = rdd_reg;
  assign reg_rvld = rvld_reg;
  assign reg_err  = err_reg;

endmodule

// File: tb/tb_qwi_reg_bank.sv
// Randomized and directed bench for qwi_reg_bank with REGCNT=8, DWID=32.
// Honours QWI_REG_SHADOW_EN when the build defines it.
module tb_qwi_reg_bank;

  localparam int NREG = 8;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam logic [NREG*DW-1:0] INIT_V = {
    32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
    32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678
  };
  // reg0 RW, reg1 RO, reg2 W1C, reg3 PULSE, reg4..7 RW
  localparam logic [2*NREG-1:0] MODE_V = 16'h00E4;

  logic              reg_clk = 1'b0;
  logic              reg_rst;
  logic              reg_ce;
  logic [DW/8-1:0]   reg_we;
  logic              reg_re;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wrd;
  logic [DW-1:0]     reg_rdd;
  logic              reg_rvld;
  logic              reg_err;
  logic [NREG*DW-1:0] reg_in;
  logic [NREG*DW-1:0] reg_evt;
  logic              reg_commit;
  logic [NREG*DW-1:0] reg_out;

  qwi_reg_bank #(
    .REGCNT   (NREG),
    .AWID     (AW),
    .DWID     (DW),
    .REG_INIT (INIT_V),
    .REG_MODE (MODE_V)
  ) dut (
    .reg_clk    (reg_clk),
    .reg_rst    (reg_rst),
    .reg_ce     (reg_ce),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_addr   (reg_addr),
    .reg_wrd    (reg_wrd),
    .reg_rdd    (reg_rdd),
    .reg_rvld   (reg_rvld),
    .reg_err    (reg_err),
    .reg_in     (reg_in),
    .reg_evt    (reg_evt),
    .reg_commit (reg_commit),
    .reg_out    (reg_out)
  );

  always #5 reg_clk = ~reg_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0=RW 1=RO 2=W1C 3=PULSE
  int          mode_of [NREG] = '{0, 1, 2, 3, 0, 0, 0, 0};
  logic [31:0] m_val [NREG];   // value a read returns (shadow for RW when shadowed)
  logic [31:0] m_com [NREG];   // committed RW value seen by fabric in shadow builds
  logic [31:0] m_rdd  = '0;
  logic        m_rvld = 1'b0;
  logic        m_err  = 1'b0;

  function automatic logic [NREG*DW-1:0] exp_out();
    logic [NREG*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
`ifdef QWI_REG_SHADOW_EN
      v[i*32 +: 32] = (mode_of[i] == 0) ? m_com[i] : m_val[i];
`else
      v[i*32 +: 32] = m_val[i];
`endif
    end
    return v;
  endfunction

  task automatic model_clock();
    logic [31:0] mask;
    logic [31:0] wbits;
    bit wr, rd, ok, hit;
    int a;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{reg_we[b]}};
    if (reg_rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_val[i] = (mode_of[i] <= 1) ? INIT_V[i*32 +: 32] : 32'h0;
        m_com[i] = INIT_V[i*32 +: 32];
      end
      m_rdd = '0; m_rvld = 1'b0; m_err = 1'b0;
    end else begin
      wr = reg_ce && (reg_we != 0);
      rd = reg_ce && reg_re;
      ok = (reg_addr < AW'(NREG));
      a  = int'(reg_addr);
      m_rvld = rd;
      m_err  = (wr || rd) && !ok;
      if (rd) m_rdd = !ok ? 32'h0 : (mode_of[a] == 3) ? 32'h0 : m_val[a];
      for (int i = 0; i < NREG; i++) begin
        hit   = wr && ok && (a == i);
        wbits = hit ? (reg_wrd & mask) : 32'h0;
        case (mode_of[i])
          0: begin
`ifdef QWI_REG_SHADOW_EN
            if (reg_commit) m_com[i] = m_val[i];
`endif
            m_val[i] = hit ? ((m_val[i] & ~mask) | wbits) : m_val[i];
          end
          1: m_val[i] = reg_in[i*32 +: 32];
          2: m_val[i] = (m_val[i] & ~wbits) | reg_evt[i*32 +: 32];
          default: m_val[i] = wbits;
        endcase
      end
    end
  endtask

  task automatic tick();
    if (reg_ce)
      $display("txn t=%0t addr=%0d we=%b re=%b wrd=%h commit=%b rst=%b",
               $time, reg_addr, reg_we, reg_re, reg_wrd, reg_commit, reg_rst);
    model_clock();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic idle();
    reg_ce = 1'b0; reg_we = '0; reg_re = 1'b0; reg_addr = '0; reg_wrd = '0;
    reg_evt = '0; reg_commit = 1'b0;
  endtask

  task automatic access(input int addr, input logic [3:0] we, input logic re,
                        input logic [31:0] data);
    reg_ce = 1'b1; reg_we = we; reg_re = re; reg_addr = AW'(addr); reg_wrd = data;
  endtask

  task automatic test_reset();
    reg_rst = 1'b1;
    idle();
    tick();
    tick();
    n_checks++;
    if (reg_rvld !== 1'b0 || reg_err !== 1'b0 || reg_rdd !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ports: rdd=%h rvld=%b err=%b required 0/0/0", reg_rdd, reg_rvld, reg_err);
    end
    n_checks++;
    if (reg_out !== INIT_V) begin
      n_errors++;
      $display("FAIL reset_out: got %h required %h", reg_out, INIT_V);
    end
    reg_rst = 1'b0;
  endtask

  task automatic test_partial_write();
    access(0, 4'b0101, 1'b0, 32'hAABB_CCDD);
    tick();
    n_checks++;
    if (reg_out !== exp_out()) begin
      n_errors++;
      $display("FAIL partial_out: got %h required %h", reg_out[31:0], exp_out()[31:0]);
    end
    access(0, 4'b0000, 1'b1, 32'h0);
    tick();
    n_checks++;
    if (reg_rvld !== 1'b1 || reg_rdd !== 32'h12BB_56DD) begin
      n_errors++;
      $display("FAIL partial_read: rdd=%h rvld=%b required 12bb56dd/1", reg_rdd, reg_rvld);
    end
    // read and write the same address together: read sees the old value
    access(0, 4'b1111, 1'b1, 32'hFFFF_FFFF);
    tick();
    n_checks++;
    if (reg_rdd !== 32'h12BB_56DD) begin
      n_errors++;
      $display("FAIL rd_wr_same: got %h required 12bb56dd", reg_rdd);
    end
    access(0, 4'b0000, 1'b1, 32'h0);
    tick();
    n_checks++;
    if (reg_rdd !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL rd_after_wr: got %h required ffffffff", reg_rdd);
    end
    idle();
    tick();
    n_checks++;
    if (reg_rvld !== 1'b0 || reg_rdd !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL rdd_hold: rdd=%h rvld=%b required ffffffff/0", reg_rdd, reg_rvld);
    end
  endtask

  task automatic test_w1c();
    idle();
    reg_evt[2*32+3] = 1'b1;
    tick();
    n_checks++;
    if (reg_out[2*32+3] !== 1'b1) begin
      n_errors++;
      $display("FAIL w1c_set: got %b required 1", reg_out[2*32+3]);
    end
    access(2, 4'b1111, 1'b0, 32'h8);
    reg_evt[2*32+3] = 1'b1;
    tick();
    n_checks++;
    if (reg_out[2*32+3] !== 1'b1) begin
      n_errors++;
      $display("FAIL w1c_set_wins: got %b required 1", reg_out[2*32+3]);
    end
    reg_evt = '0;
    access(2, 4'b1111, 1'b0, 32'h8);
    tick();
    n_checks++;
    if (reg_out[2*32 +: 32] !== 32'h0) begin
      n_errors++;
      $display("FAIL w1c_clear: got %h required 0", reg_out[2*32 +: 32]);
    end
    idle();
  endtask

  task automatic test_pulse();
    access(3, 4'b1111, 1'b0, 32'h5);
    tick();
    n_checks++;
    if (reg_out[3*32 +: 32] !== 32'h5) begin
      n_errors++;
      $display("FAIL pulse_on: got %h required 5", reg_out[3*32 +: 32]);
    end
    idle();
    tick();
    n_checks++;
    if (reg_out[3*32 +: 32] !== 32'h0) begin
      n_errors++;
      $display("FAIL pulse_off: got %h required 0", reg_out[3*32 +: 32]);
    end
    access(0, 4'b0000, 1'b1, 32'h0);
    tick();
    access(3, 4'b0000, 1'b1, 32'h0);
    tick();
    n_checks++;
    if (reg_rvld !== 1'b1 || reg_rdd !== 32'h0) begin
      n_errors++;
      $display("FAIL pulse_read: rdd=%h rvld=%b required 0/1", reg_rdd, reg_rvld);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    for (int k = 8; k <= 9; k++) begin
      access(k, 4'b1111, 1'b0, 32'hFFFF_FFFF);
      tick();
      n_checks++;
      if (reg_err !== 1'b1 || reg_out !== exp_out()) begin
        n_errors++;
        $display("FAIL oor_write_%0d: err=%b out=%h required 1/%h", k, reg_err, reg_out, exp_out());
      end
    end
    access(0, 4'b0000, 1'b1, 32'h0);
    tick();
    access(9, 4'b0000, 1'b1, 32'h0);
    tick();
    n_checks++;
    if (reg_rdd !== 32'h0 || reg_rvld !== 1'b1 || reg_err !== 1'b1) begin
      n_errors++;
      $display("FAIL oor_read: rdd=%h rvld=%b err=%b required 0/1/1", reg_rdd, reg_rvld, reg_err);
    end
    access(7, 4'b0000, 1'b1, 32'h0);
    tick();
    n_checks++;
    if (reg_rdd !== 32'h7777_0007 || reg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL last_reg_read: rdd=%h err=%b required 77770007/0", reg_rdd, reg_err);
    end
    idle();
    tick();
    n_checks++;
    if (reg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_pulse_len: got %b required 0", reg_err);
    end
  endtask

`ifdef QWI_REG_SHADOW_EN
  task automatic test_shadow();
    logic [31:0] before;
    before = m_com[0];
    access(0, 4'b1111, 1'b0, 32'h1);
    tick();
    n_checks++;
    if (reg_out[31:0] !== before) begin
      n_errors++;
      $display("FAIL shadow_hold: got %h required %h", reg_out[31:0], before);
    end
    access(0, 4'b1111, 1'b0, 32'h2);
    reg_commit = 1'b1;
    tick();
    n_checks++;
    if (reg_out[31:0] !== 32'h1) begin
      n_errors++;
      $display("FAIL shadow_commit: got %h required 1", reg_out[31:0]);
    end
    access(0, 4'b0000, 1'b1, 32'h0);
    reg_commit = 1'b0;
    tick();
    n_checks++;
    if (reg_out[31:0] !== 32'h1 || reg_rdd !== 32'h2) begin
      n_errors++;
      $display("FAIL shadow_read: out=%h rdd=%h required 1/2", reg_out[31:0], reg_rdd);
    end
    idle();
    reg_commit = 1'b1;
    tick();
    n_checks++;
    if (reg_out[31:0] !== 32'h2) begin
      n_errors++;
      $display("FAIL shadow_commit2: got %h required 2", reg_out[31:0]);
    end
    idle();
  endtask
`endif

  task automatic test_reset_mid_read();
    access(0, 4'b0000, 1'b1, 32'h0);
    tick();
    access(0, 4'b0000, 1'b1, 32'h0);
    reg_rst = 1'b1;
    tick();
    n_checks++;
    if (reg_rvld !== 1'b0 || reg_rdd !== 32'h0 || reg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_read: rdd=%h rvld=%b err=%b required 0/0/0", reg_rdd, reg_rvld, reg_err);
    end
    n_checks++;
    if (reg_out !== INIT_V) begin
      n_errors++;
      $display("FAIL rst_mid_out: got %h required %h", reg_out, INIT_V);
    end
    reg_rst = 1'b0;
    idle();
    tick();
    n_checks++;
    if (reg_rvld !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_no_rvld: got %b required 0", reg_rvld);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      reg_rst    = ($urandom_range(0, 49) == 0);
      reg_ce     = ($urandom_range(0, 3) != 0);
      reg_we     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      reg_re     = 1'($urandom_range(0, 1));
      reg_addr   = AW'($urandom_range(0, 10));
      reg_wrd    = $urandom;
      reg_commit = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NREG; i++) begin
        reg_in[i*32 +: 32]  = $urandom;
        reg_evt[i*32 +: 32] = ($urandom_range(0, 2) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
      end
      tick();
      n_checks++;
      if (reg_rvld !== m_rvld) begin
        n_errors++;
        $display("FAIL rand_rvld c=%0d: got %b required %b", c, reg_rvld, m_rvld);
      end
      n_checks++;
      if (reg_err !== m_err) begin
        n_errors++;
        $display("FAIL rand_err c=%0d: got %b required %b", c, reg_err, m_err);
      end
      n_checks++;
      if (reg_rdd !== m_rdd) begin
        n_errors++;
        $display("FAIL rand_rdd c=%0d: got %h required %h", c, reg_rdd, m_rdd);
      end
      n_checks++;
      if (reg_out !== exp_out()) begin
        n_errors++;
        $display("FAIL rand_out c=%0d: got %h required %h", c, reg_out, exp_out());
      end
    end
    reg_rst = 1'b0;
    idle();
  endtask

  initial begin
    reg_rst = 1'b1;
    reg_in  = '0;
    idle();
    @(posedge reg_clk);
    #1;
    test_reset();
    test_partial_write();
    test_w1c();
    test_pulse();
    test_out_of_range();
`ifdef QWI_REG_SHADOW_EN
    test_shadow();
`endif
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/qwi_reg_bank.md
QWI_REG_BANK -- requirements
Module: qwi_reg_bank

Interface
REQ-001 Parameter REGCNT, default 32: number of 32-bit-class registers.
REQ-002 Parameter AWID, default 12: word address width; addresses at or above REGCNT are out of range.
REQ-003 Parameter DWID, default 32: data width, a multiple of 8.
REQ-004 Parameter REG_INIT, default all zero, DWID*REGCNT bits: reset value per register.
REQ-005 Parameter REG_MODE, default all zero, 2*REGCNT bits: per-register mode with 0=RW, 1=RO, 2=W1C, 3=PULSE.
REQ-006 One clock and one reset; the reset is synchronous and active-high.
REQ-007 reg_clk  in  1  clock for all state.
REQ-008 reg_rst  in  1  synchronous active-high reset.
REQ-009 reg_ce  in  1  access strobe.
REQ-010 reg_we  in  DWID/8  byte write enables; a write occurs when reg_ce is high and any bit is set.
REQ-011 reg_re  in  1  read request, valid only with reg_ce.
REQ-012 reg_addr  in  AWID  word address.
REQ-013 reg_wrd  in  DWID  write data.
REQ-014 reg_rdd  out  DWID  registered read data.
REQ-015 reg_rvld  out  1  read data valid, one-cycle pulse.
REQ-016 reg_err  out  1  one-cycle pulse on an out-of-range access.
REQ-017 reg_in  in  DWID*REGCNT  RO sources.
REQ-018 reg_evt  in  DWID*REGCNT  W1C per-bit set events.
REQ-019 reg_commit  in  1  shadow commit strobe.
REQ-020 reg_out  out  DWID*REGCNT  register values to fabric.

Function
REQ-021 RW registers SHALL update only the enabled bytes of a write; partial-byte writes are supported.
REQ-022 RO registers SHALL capture reg_in every cycle and ignore writes.
REQ-023 W1C registers SHALL set a bit on reg_evt and clear it when that bit is written as 1 in an enabled byte; when set and clear coincide, set wins.
REQ-024 PULSE registers SHALL drive written bits on reg_out for exactly one cycle (the cycle after the write) and then read back as 0.
REQ-025 A read accepted in cycle N SHALL present reg_rdd with reg_rvld=1 in cycle N+1; reg_rdd holds its value when reg_rvld=0.
REQ-026 A read and a write to the same address in the same cycle SHALL return the pre-write value.
REQ-027 An out-of-range access SHALL: ignore the write; return reg_rdd=0 with reg_rvld=1 if it is a read; pulse reg_err in cycle N+1.
REQ-028 reg_out SHALL be registered, so a write in cycle N is visible on reg_out in cycle N+1.

Reset
REQ-029 While reg_rst is high:
- RW and RO storage SHALL load REG_INIT.
- W1C and PULSE storage SHALL load 0.
- reg_rdd, reg_rvld and reg_err SHALL be 0.
REQ-030 A read pending when reg_rst asserts SHALL be dropped, with no reg_rvld after reset.
REQ-031 Accesses SHALL take effect from the first cycle after reg_rst deasserts.

Configuration
REQ-032 Macro QWI_REG_SHADOW_EN, defined: RW writes go to a shadow copy, and reads return the shadow. reg_out for RW registers SHALL load from the shadow in the cycle after reg_commit=1. A write coinciding with reg_commit SHALL land in the shadow only and is not committed.
REQ-033 Macro QWI_REG_SHADOW_EN, undefined: no shadow storage exists, reg_commit is ignored, and REQ-028 applies to RW registers.

Structure
REQ-034 The shared package qwi_reg_pkg SHALL hold the mode encodings (MODE_RW, MODE_RO, MODE_W1C, MODE_PULSE) and the default widths.
REQ-035 The per-register logic SHALL live in the sub-module qwi_reg_cell, instantiated REGCNT times by generate. The bank SHALL hold address decode, the read mux/register and the error logic.

Verification
REQ-036 The bench SHALL use REGCNT=8 and DWID=32, with reg 0 RW (init 0x12345678), reg 1 RO, reg 2 W1C, reg 3 PULSE. It SHALL cover:
- Write reg 0 with 0xAABBCCDD and reg_we=4'b0101, then read: reg_rdd=0x12BB56DD one cycle after the read, with reg_rvld=1.
- reg_evt[2*32+3] pulses, and in the same cycle as a second pulse, write 0x8 to reg 2: bit 3 remains 1. Writing 0x8 alone then clears it to 0.
- Write 0x5 to reg 3: reg_out[3] is 0x5 for exactly one cycle, then 0. Reading reg 3 returns 0.
- Read address 9: reg_rdd=0, reg_rvld=1 and reg_err=1 one cycle later. A write to address 9 changes nothing.
- With QWI_REG_SHADOW_EN, write 0x1 to reg 0: reg_out[0] is unchanged until one cycle after reg_commit. A write in the commit cycle is not committed.
- Assert reg_rst mid-read: reg_rvld stays 0, and all outputs match REQ-029 on the next cycle.
